// File: rtl/m_msub_div_pkg.sv
// Shared types and constants for the m_msub_div divide-by-3 recovery block.
package m_msub_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DIVISOR = 3;
    localparam int unsigned Y_W     = 32;
    localparam int unsigned B_W     = 16;
    localparam int unsigned CNT_W   = 5;

endpackage

// File: rtl/m_div3_step.sv
// One restoring step of a bit-serial divide by DIVISOR: shifts a dividend bit
// into the 2-bit partial remainder and emits the quotient bit.
module m_div3_step
    import m_msub_div_pkg::*;
(
    input  logic [1:0] rem,
    input  logic       bit_in,
    output logic       qbit,
    output logic [1:0] rem_nx
);

    logic [2:0] t;

    always_comb begin
        t      = {rem, bit_in};
        qbit   = 1'b0;
        rem_nx = t[1:0];
        if (t >= 3'(DIVISOR)) begin
            qbit   = 1'b1;
            rem_nx = 2'(t - 3'(DIVISOR));
        end
    end

endmodule

// File: rtl/m_msub_div.sv
// Recovers b = (y - c) / 3 with remainder and range flags over valid/ready.
// Optional build macro: M_MSUB_DIV_SAT_EN saturates r_b to all-ones on overflow.
module m_msub_div
    import m_msub_div_pkg::*;
(
    input  logic            w_clk,
    input  logic            w_rst,
    input  logic            w_valid,
    output logic            r_ready,
    input  logic [Y_W-1:0]  w_y,
    input  logic [Y_W-1:0]  w_c,
    output logic            r_valid,
    input  logic            w_ready,
    output logic [B_W-1:0]  r_b,
    output logic [1:0]      r_rem,
    output logic            r_ovf,
    output logic            r_unf
);

    state_t           state, state_nx;
    logic [Y_W-1:0]   diff;
    logic [Y_W-1:0]   quo, quo_nx;
    logic [1:0]       rem, rem_nx;
    logic [CNT_W-1:0] cnt;
    logic             unf_q;
    logic             qbit;
    logic             ovf_nx;
    logic [B_W-1:0]   b_nx;

    m_div3_step u_step (
        .rem    (rem),
        .bit_in (diff[cnt]),
        .qbit   (qbit),
        .rem_nx (rem_nx)
    );

    always_comb begin
        quo_nx = {quo[Y_W-2:0], qbit};
        ovf_nx = |quo_nx[Y_W-1:B_W];
`ifdef M_MSUB_DIV_SAT_EN
        b_nx   = ovf_nx ? '1 : quo_nx[B_W-1:0];
`else
        b_nx   = quo_nx[B_W-1:0];
`endif
    end

    always_comb begin
        state_nx = state;
        r_ready  = 1'b0;
        r_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                r_ready = 1'b1;
                if (w_valid) state_nx = ST_DIV;
            end
            ST_DIV: begin
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                r_valid = 1'b1;
                if (w_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= ST_IDLE;
            diff  <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
            unf_q <= 1'b0;
            r_b   <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (w_valid) begin
                        diff  <= w_y - w_c;
                        unf_q <= (w_c > w_y);
                        quo   <= '0;
                        rem   <= '0;
                        cnt   <= CNT_W'(Y_W - 1);
                    end
                end
                ST_DIV: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt - 1'b1;
                    // Last step: outputs take the post-step quotient/remainder.
                    if (cnt == '0) begin
                        r_unf <= unf_q;
                        if (unf_q) begin
                            r_b   <= '0;
                            r_rem <= '0;
                            r_ovf <= 1'b0;
                        end else begin
                            r_b   <= b_nx;
                            r_rem <= rem_nx;
                            r_ovf <= ovf_nx;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
